wb_stage_pipe: RTL and testbench

- Parametrised successor to the write-back stage of the 5-stage RV32I pipeline.
- Owns the MEM/WB pipeline register with valid/stall/flush control.
- Performs load byte/half/word extraction and sign/zero extension, then selects among ALU, load and PC+4 results to drive the register-file write port and the forwarding bus.
- Sits between the MEM stage and the register file.

---
 rtl/wb_pkg.sv | 33 +++
 rtl/wb_load_ext.sv | 63 ++++++
 rtl/wb_stage_pipe.sv | 110 +++++++++++
 tb/tb_wb_stage_pipe.sv | 201 ++++++++++++++++++++
 4 files changed

// File: rtl/wb_pkg.sv
// Shared types for the write-back stage.
// Stage payload fields use the widest legal XLEN (64) and a fixed 8-bit rd.
// Narrower builds zero-pad on capture and slice on use, so NREGS <= 256.
package wb_pkg;

  localparam int unsigned XLEN_MAX = 64;
  localparam int unsigned RA_MAX   = 8;

  typedef enum logic [1:0] {
    WB_ALU  = 2'd0,
    WB_LOAD = 2'd1,
    WB_PC4  = 2'd2
  } wb_sel_e;

  typedef enum logic [1:0] {
    LD_B = 2'd0,
    LD_H = 2'd1,
    LD_W = 2'd2
  } ld_size_e;

  typedef struct packed {
    logic                valid;
    logic [XLEN_MAX-1:0] alu;
    logic [XLEN_MAX-1:0] rdata;
    logic [XLEN_MAX-1:0] pc4;
    logic                reg_write;
    wb_sel_e             wb_sel;
    ld_size_e            ld_size;
    logic                ld_unsigned;
    logic [RA_MAX-1:0]   rd;
  } wb_stage_t;

endpackage

// File: rtl/wb_load_ext.sv
// Load lane select, sign/zero extension and misalignment detection (combinational).
// Ports: rdata (aligned memory data), addr_lo (byte offset), ld_size, ld_unsigned,
//        is_load (selected source is a load) -> data_c (extended value), misalign_c.
module wb_load_ext
  import wb_pkg::*;
#(
  parameter int unsigned XLEN = 32
) (
  input  logic [XLEN-1:0] rdata,
  input  logic [1:0]      addr_lo,
  input  ld_size_e        ld_size,
  input  logic            ld_unsigned,
  input  logic            is_load,
  output logic [XLEN-1:0] data_c,
  output logic            misalign_c
);

  logic [31:0] word_lane;
  logic [15:0] half_lane;
  logic [7:0]  byte_lane;

  // Word loads only ever look at the low 32 bits of the returned data.
  generate
    if (XLEN > 32) begin : g_hi_unused
      logic unused_rdata_hi;
      assign unused_rdata_hi = ^rdata[XLEN-1:32];
    end
  endgenerate

  always_comb begin
    word_lane = rdata[31:0];
    half_lane = addr_lo[1] ? word_lane[31:16] : word_lane[15:0];
    case (addr_lo)
      2'd0:    byte_lane = word_lane[7:0];
      2'd1:    byte_lane = word_lane[15:8];
      2'd2:    byte_lane = word_lane[23:16];
      default: byte_lane = word_lane[31:24];
    endcase
  end

  // Size encoding 11 behaves as a word load.
  always_comb begin
    data_c     = '0;
    misalign_c = 1'b0;
    case (ld_size)
      LD_B: begin
        if (ld_unsigned) data_c = XLEN'(byte_lane);
        else             data_c = XLEN'($signed(byte_lane));
      end
      LD_H: begin
        if (ld_unsigned) data_c = XLEN'(half_lane);
        else             data_c = XLEN'($signed(half_lane));
        misalign_c = is_load & addr_lo[0];
      end
      default: begin
        if (ld_unsigned) data_c = XLEN'(word_lane);
        else             data_c = XLEN'($signed(word_lane));
        misalign_c = is_load & (addr_lo != 2'd0);
      end
    endcase
  end

endmodule

// File: rtl/wb_stage_pipe.sv
// Write-back stage: MEM/WB pipeline register plus result select.
// Ports: clk, rst_ (sync, active-high); mem_* MEM-stage result and control;
//        wb_stall / wb_flush register control; rf_we/rf_waddr/rf_wdata register-file
//        write port; misalign_err; fwd_valid (mirrors rf_we).
// Optional: define WB_RETIRE_CNT_EN to add the 64-bit retire_cnt output.
module wb_stage_pipe
  import wb_pkg::*;
#(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned NREGS = 32
) (
  input  logic                       clk,
  input  logic                       rst_,
  input  logic                       mem_valid,
  input  logic [XLEN-1:0]            mem_alu,
  input  logic [XLEN-1:0]            mem_rdata,
  input  logic [XLEN-1:0]            mem_pc4,
  input  logic                       mem_reg_write,
  input  logic [1:0]                 mem_wb_sel,
  input  logic [1:0]                 mem_ld_size,
  input  logic                       mem_ld_unsigned,
  input  logic [$clog2(NREGS)-1:0]   mem_rd_addr,
  input  logic                       wb_stall,
  input  logic                       wb_flush,
  output logic                       rf_we,
  output logic [$clog2(NREGS)-1:0]   rf_waddr,
  output logic [XLEN-1:0]            rf_wdata,
  output logic                       misalign_err,
`ifdef WB_RETIRE_CNT_EN
  output logic [63:0]                retire_cnt,
`endif
  output logic                       fwd_valid
);

  localparam int unsigned RA_W = $clog2(NREGS);

  wb_stage_t       stage_q;
  wb_stage_t       stage_d;
  logic [XLEN-1:0] ld_data_c;
  logic            ld_misalign_c;
  logic            is_load_c;

  // Padding bits of the stage payload exist only in narrow builds.
  logic unused_stage;
  assign unused_stage = ^{stage_q.alu, stage_q.rdata, stage_q.pc4, stage_q.rd};

  // Zero-pad MEM inputs into the stage payload.
  always_comb begin
    stage_d             = '0;
    stage_d.valid       = mem_valid;
    stage_d.alu         = XLEN_MAX'(mem_alu);
    stage_d.rdata       = XLEN_MAX'(mem_rdata);
    stage_d.pc4         = XLEN_MAX'(mem_pc4);
    stage_d.reg_write   = mem_reg_write;
    stage_d.wb_sel      = wb_sel_e'(mem_wb_sel);
    stage_d.ld_size     = ld_size_e'(mem_ld_size);
    stage_d.ld_unsigned = mem_ld_unsigned;
    stage_d.rd          = RA_MAX'(mem_rd_addr);
  end

  // MEM/WB register: reset > flush > stall > load.
  always_ff @(posedge clk) begin
    if (rst_) begin
      stage_q <= '0;
    end else if (wb_flush) begin
      stage_q.valid <= 1'b0;
    end else if (!wb_stall) begin
      stage_q <= stage_d;
    end
  end

  assign is_load_c = (stage_q.wb_sel == WB_LOAD);

  wb_load_ext #(.XLEN(XLEN)) u_load_ext (
    .rdata       (stage_q.rdata[XLEN-1:0]),
    .addr_lo     (stage_q.alu[1:0]),
    .ld_size     (stage_q.ld_size),
    .ld_unsigned (stage_q.ld_unsigned),
    .is_load     (is_load_c),
    .data_c      (ld_data_c),
    .misalign_c  (ld_misalign_c)
  );

  // Result select and write enable, driven only from the stage register.
  always_comb begin
    rf_wdata = stage_q.alu[XLEN-1:0];
    case (stage_q.wb_sel)
      WB_LOAD: rf_wdata = ld_data_c;
      WB_PC4:  rf_wdata = stage_q.pc4[XLEN-1:0];
      default: rf_wdata = stage_q.alu[XLEN-1:0];
    endcase
    rf_waddr     = stage_q.rd[RA_W-1:0];
    misalign_err = stage_q.valid & ld_misalign_c;
    rf_we        = stage_q.valid & stage_q.reg_write &
                   (stage_q.rd[RA_W-1:0] != RA_W'(0)) & ~ld_misalign_c;
    fwd_valid    = rf_we;
  end

`ifdef WB_RETIRE_CNT_EN
  // One count per instruction, on the edge it leaves WB; rd and reg_write ignored.
  always_ff @(posedge clk) begin
    if (rst_) begin
      retire_cnt <= '0;
    end else if (stage_q.valid && !ld_misalign_c && !wb_stall) begin
      retire_cnt <= retire_cnt + 64'd1;
    end
  end
`endif

endmodule

// File: tb/tb_wb_stage_pipe.sv
// Directed bench for wb_stage_pipe (XLEN=32, NREGS=32).
module tb_wb_stage_pipe;

  logic        clk;
  logic        rst_;
  logic        mem_valid;
  logic [31:0] mem_alu;
  logic [31:0] mem_rdata;
  logic [31:0] mem_pc4;
  logic        mem_reg_write;
  logic [1:0]  mem_wb_sel;
  logic [1:0]  mem_ld_size;
  logic        mem_ld_unsigned;
  logic [4:0]  mem_rd_addr;
  logic        wb_stall;
  logic        wb_flush;
  logic        rf_we;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;
  logic        misalign_err;
  logic        fwd_valid;
`ifdef WB_RETIRE_CNT_EN
  logic [63:0] retire_cnt;
`endif

  int n_checks = 0;
  int n_errors = 0;

  wb_stage_pipe #(.XLEN(32), .NREGS(32)) dut (
    .clk             (clk),
    .rst_            (rst_),
    .mem_valid       (mem_valid),
    .mem_alu         (mem_alu),
    .mem_rdata       (mem_rdata),
    .mem_pc4         (mem_pc4),
    .mem_reg_write   (mem_reg_write),
    .mem_wb_sel      (mem_wb_sel),
    .mem_ld_size     (mem_ld_size),
    .mem_ld_unsigned (mem_ld_unsigned),
    .mem_rd_addr     (mem_rd_addr),
    .wb_stall        (wb_stall),
    .wb_flush        (wb_flush),
    .rf_we           (rf_we),
    .rf_waddr        (rf_waddr),
    .rf_wdata        (rf_wdata),
    .misalign_err    (misalign_err),
`ifdef WB_RETIRE_CNT_EN
    .retire_cnt      (retire_cnt),
`endif
    .fwd_valid       (fwd_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Advance one edge and settle just after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [31:0] alu, input logic [31:0] rdata,
                       input logic [31:0] pc4, input logic rw, input logic [1:0] sel,
                       input logic [1:0] sz, input logic uns, input logic [4:0] rd);
    mem_valid       = v;
    mem_alu         = alu;
    mem_rdata       = rdata;
    mem_pc4         = pc4;
    mem_reg_write   = rw;
    mem_wb_sel      = sel;
    mem_ld_size     = sz;
    mem_ld_unsigned = uns;
    mem_rd_addr     = rd;
  endtask

  task automatic check_out(input string tag, input logic we, input logic [4:0] wa,
                           input logic [31:0] wd, input logic mis);
    check({tag, ".we"},  64'(rf_we), 64'(we));
    check({tag, ".fwd"}, 64'(fwd_valid), 64'(we));
    check({tag, ".wa"},  64'(rf_waddr), 64'(wa));
    check({tag, ".wd"},  64'(rf_wdata), 64'(wd));
    check({tag, ".mis"}, 64'(misalign_err), 64'(mis));
  endtask

  initial begin
    rst_     = 1'b1;
    wb_stall = 1'b0;
    wb_flush = 1'b0;
    drive(1'b1, 32'h55, 32'h0, 32'h0, 1'b1, 2'b00, 2'b10, 1'b0, 5'd5);

    // Reset held two cycles with a valid writer on the inputs.
    step(); check_out("rst0", 1'b0, 5'd0, 32'h0, 1'b0);
    step(); check_out("rst1", 1'b0, 5'd0, 32'h0, 1'b0);
    rst_ = 1'b0;
    step(); check_out("rst_rel", 1'b1, 5'd5, 32'h55, 1'b0);

    // ALU write, then the same to x0.
    drive(1'b1, 32'h1234_5678, 32'h0, 32'h0, 1'b1, 2'b00, 2'b10, 1'b0, 5'd10);
    step(); check_out("alu", 1'b1, 5'd10, 32'h1234_5678, 1'b0);
    mem_rd_addr = 5'd0;
    step(); check_out("alu_x0", 1'b0, 5'd0, 32'h1234_5678, 1'b0);
    mem_reg_write = 1'b0; mem_rd_addr = 5'd3;
    step(); check_out("alu_norw", 1'b0, 5'd3, 32'h1234_5678, 1'b0);

    // Loads from 0xDEADBEEF.
    drive(1'b1, 32'h0000_1003, 32'hDEAD_BEEF, 32'h0, 1'b1, 2'b01, 2'b00, 1'b0, 5'd4);
    step(); check_out("lb3", 1'b1, 5'd4, 32'hFFFF_FFDE, 1'b0);
    drive(1'b1, 32'h0000_1000, 32'hDEAD_BEEF, 32'h0, 1'b1, 2'b01, 2'b00, 1'b1, 5'd4);
    step(); check_out("lbu0", 1'b1, 5'd4, 32'h0000_00EF, 1'b0);
    drive(1'b1, 32'h0000_1001, 32'hDEAD_BEEF, 32'h0, 1'b1, 2'b01, 2'b00, 1'b0, 5'd4);
    step(); check_out("lb1", 1'b1, 5'd4, 32'hFFFF_FFBE, 1'b0);
    drive(1'b1, 32'h0000_1002, 32'hDEAD_BEEF, 32'h0, 1'b1, 2'b01, 2'b01, 1'b0, 5'd6);
    step(); check_out("lh2", 1'b1, 5'd6, 32'hFFFF_DEAD, 1'b0);
    drive(1'b1, 32'h0000_1000, 32'hDEAD_BEEF, 32'h0, 1'b1, 2'b01, 2'b01, 1'b1, 5'd6);
    step(); check_out("lhu0", 1'b1, 5'd6, 32'h0000_BEEF, 1'b0);
    drive(1'b1, 32'h0000_1000, 32'h1234_7FFF, 32'h0, 1'b1, 2'b01, 2'b01, 1'b0, 5'd6);
    step(); check_out("lh_pos", 1'b1, 5'd6, 32'h0000_7FFF, 1'b0);
    drive(1'b1, 32'h0000_1000, 32'hDEAD_BEEF, 32'h0, 1'b1, 2'b01, 2'b10, 1'b0, 5'd7);
    step(); check_out("lw0", 1'b1, 5'd7, 32'hDEAD_BEEF, 1'b0);
    drive(1'b1, 32'h0000_1000, 32'hDEAD_BEEF, 32'h0, 1'b1, 2'b01, 2'b11, 1'b0, 5'd7);
    step(); check_out("lsz3", 1'b1, 5'd7, 32'hDEAD_BEEF, 1'b0);
    drive(1'b1, 32'h0000_1001, 32'hDEAD_BEEF, 32'h0, 1'b1, 2'b01, 2'b10, 1'b0, 5'd7);
    step(); check({"lw1", ".we"}, 64'(rf_we), 64'd0);
    check({"lw1", ".mis"}, 64'(misalign_err), 64'd1);
    drive(1'b1, 32'h0000_1003, 32'hDEAD_BEEF, 32'h0, 1'b1, 2'b01, 2'b01, 1'b0, 5'd7);
    step(); check({"lh3", ".we"}, 64'(rf_we), 64'd0);
    check({"lh3", ".mis"}, 64'(misalign_err), 64'd1);
    // Misaligned address but the ALU result is selected (sel 11): no error.
    drive(1'b1, 32'h0000_1001, 32'hDEAD_BEEF, 32'h0, 1'b1, 2'b11, 2'b10, 1'b0, 5'd8);
    step(); check_out("sel3", 1'b1, 5'd8, 32'h0000_1001, 1'b0);
    // Misaligned load in an invalid slot: no error flag.
    drive(1'b0, 32'h0000_1001, 32'hDEAD_BEEF, 32'h0, 1'b1, 2'b01, 2'b10, 1'b0, 5'd8);
    step(); check({"inv_mis", ".mis"}, 64'(misalign_err), 64'd0);
    check({"inv_mis", ".we"}, 64'(rf_we), 64'd0);

    // Link write.
    drive(1'b1, 32'h0000_2000, 32'h0, 32'h0000_0104, 1'b1, 2'b10, 2'b10, 1'b0, 5'd1);
    step(); check_out("link", 1'b1, 5'd1, 32'h0000_0104, 1'b0);

    // Stall three cycles while inputs change.
    drive(1'b1, 32'h0000_AAAA, 32'h0, 32'h0, 1'b1, 2'b00, 2'b10, 1'b0, 5'd7);
    step(); check_out("pre_stall", 1'b1, 5'd7, 32'h0000_AAAA, 1'b0);
    wb_stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 32'h0000_BB00 + 32'(i), 32'h0, 32'h0, 1'b1, 2'b00, 2'b10, 1'b0, 5'd9);
      step(); check_out($sformatf("stall%0d", i), 1'b1, 5'd7, 32'h0000_AAAA, 1'b0);
    end
    wb_stall = 1'b0;
    step(); check_out("unstall", 1'b1, 5'd9, 32'h0000_BB02, 1'b0);

    // Stall and flush together: flush wins.
    wb_stall = 1'b1; wb_flush = 1'b1;
    step(); check({"stflush", ".we"}, 64'(rf_we), 64'd0);
    check({"stflush", ".fwd"}, 64'(fwd_valid), 64'd0);
    wb_stall = 1'b0; wb_flush = 1'b0;
    drive(1'b1, 32'h0000_0C0C, 32'h0, 32'h0, 1'b1, 2'b00, 2'b10, 1'b0, 5'd12);
    step(); check_out("post_flush", 1'b1, 5'd12, 32'h0000_0C0C, 1'b0);

    // Reset mid-stream with stall and flush also asserted.
    rst_ = 1'b1; wb_stall = 1'b1; wb_flush = 1'b1;
    step(); check_out("rst_mid", 1'b0, 5'd0, 32'h0, 1'b0);
    rst_ = 1'b0; wb_stall = 1'b0; wb_flush = 1'b0;
    step(); check_out("rst_mid_rel", 1'b1, 5'd12, 32'h0000_0C0C, 1'b0);

`ifdef WB_RETIRE_CNT_EN
    // Five entries: E2 stalled two cycles, E4 misaligned -> four retirements.
    rst_ = 1'b1;
    step(); check("rc_rst", retire_cnt, 64'd0);
    rst_ = 1'b0;
    drive(1'b1, 32'h10, 32'h0, 32'h0, 1'b1, 2'b00, 2'b10, 1'b0, 5'd1);
    step();
    drive(1'b1, 32'h20, 32'h0, 32'h0, 1'b1, 2'b00, 2'b10, 1'b0, 5'd0);
    step();
    drive(1'b1, 32'h30, 32'h0, 32'h0, 1'b0, 2'b00, 2'b10, 1'b0, 5'd3);
    wb_stall = 1'b1;
    step(); step();
    check("rc_stall", retire_cnt, 64'd1);
    wb_stall = 1'b0;
    step();
    drive(1'b1, 32'h41, 32'h0, 32'h0, 1'b1, 2'b01, 2'b10, 1'b0, 5'd4);
    step();
    drive(1'b1, 32'h50, 32'h0, 32'h0, 1'b1, 2'b00, 2'b10, 1'b0, 5'd5);
    step();
    mem_valid = 1'b0;
    step(); step();
    check("rc_final", retire_cnt, 64'd4);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
